// File: rtl/fft64_ctrl_if.sv
// Handshake and buffer-bus signals between the 64-point FFT sequencer,
// the sample buffer and the 8-point core.
interface fft64_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [2:0] rd_grp;
  logic       rd_pass;
  logic       core_vld;
  logic [2:0] wn_grp;
  logic       core_vld_out;
  logic       wr_en;
  logic [2:0] wr_grp;
  logic       wr_pass;
  logic       err;

  modport master (
    input  start, core_vld_out,
    output busy, done, rd_en, rd_grp, rd_pass, core_vld, wn_grp,
           wr_en, wr_grp, wr_pass, err
  );

  modport slave (
    output start, core_vld_out,
    input  busy, done, rd_en, rd_grp, rd_pass, core_vld, wn_grp,
           wr_en, wr_grp, wr_pass, err
  );
endinterface

// File: rtl/fft64_ctrl.sv
// Two-pass (8 x 8) sequencer that runs a 64-point FFT through an 8-point core.
// Optional WAIT-state watchdog is built when FFT64_CTRL_TIMEOUT_EN is defined.
module fft64_ctrl #(
  parameter int CORE_LAT = 2,
  parameter int TO_CYC   = 16
) (
  input logic          clk,
  input logic          rst,
  fft64_ctrl_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RD0   | pass-0 buffer reads, groups 0..7
  // WAIT0 | collecting remaining pass-0 core results
  // RD1   | pass-1 buffer reads, groups 0..7
  // WAIT1 | collecting remaining pass-1 core results
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    WAIT0 = 3'd2,
    RD1   = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  if (CORE_LAT < 1 || TO_CYC < 1) begin : g_param_chk
    $error("fft64_ctrl: CORE_LAT and TO_CYC must be at least 1");
  end

  state_t     state;
  state_t     state_nxt;
  logic [2:0] rd_cnt;
  logic [3:0] wr_cnt;
  logic       core_vld_q;
  logic [2:0] wn_grp_q;
  logic       err_q;

  logic in_rd;
  logic in_wait;
  logic in_pass;
  logic pass1;
  logic wr_ok;
  logic wr_en;
  logic pass_wr_done;
  logic err_set;

  assign in_rd   = (state == RD0) || (state == RD1);
  assign in_wait = (state == WAIT0) || (state == WAIT1);
  assign in_pass = in_rd || in_wait;
  assign pass1   = (state == RD1) || (state == WAIT1);

  // wr_cnt[3] marks that all eight results of the pass were already taken
  assign wr_ok        = in_pass && !wr_cnt[3];
  assign wr_en        = bus.core_vld_out && wr_ok;
  assign pass_wr_done = (wr_en && (wr_cnt == 4'd7)) || wr_cnt[3];

`ifdef FFT64_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_fire;

  // to_cnt holds cycles since the last accepted write; fire on the edge it reaches TO_CYC
  assign to_fire = in_wait && !wr_en && (to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_pass) begin
      to_cnt <= '0;
    end else if (wr_en) begin
      to_cnt <= TO_W'(1);
    end else if (in_wait) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign err_set = (bus.core_vld_out && !wr_ok) || to_fire;
`else
  assign err_set = bus.core_vld_out && !wr_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RD0;
      RD0:     if (rd_cnt == 3'd7) state_nxt = WAIT0;
      WAIT0:   if (pass_wr_done) state_nxt = RD1;
      RD1:     if (rd_cnt == 3'd7) state_nxt = WAIT1;
      WAIT1:   if (pass_wr_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef FFT64_CTRL_TIMEOUT_EN
    if (to_fire) state_nxt = IDLE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 3'd0;
    end else if (in_rd) begin
      rd_cnt <= rd_cnt + 3'd1;
    end else begin
      rd_cnt <= 3'd0;
    end
  end

  // write count restarts whenever a new pass begins or the run ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= 4'd0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == RD0) || (state_nxt == RD1) || (state_nxt == IDLE))) begin
      wr_cnt <= 4'd0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 4'd1;
    end
  end

  // buffer read data reaches the core one cycle after the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_vld_q <= 1'b0;
      wn_grp_q   <= 3'd0;
    end else begin
      core_vld_q <= in_rd;
      wn_grp_q   <= rd_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if ((state == IDLE) && bus.start) begin
      err_q <= 1'b0;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.rd_en    = in_rd;
  assign bus.rd_grp   = rd_cnt;
  assign bus.rd_pass  = (state == RD1);
  assign bus.core_vld = core_vld_q;
  assign bus.wn_grp   = wn_grp_q;
  assign bus.wr_en    = wr_en;
  assign bus.wr_grp   = wr_cnt[2:0];
  assign bus.wr_pass  = pass1;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_fft64_ctrl.sv
// Scoreboard bench for fft64_ctrl: directed runs push expected events,
// a negedge monitor pops and compares them against the DUT.
module tb_fft64_ctrl;
  localparam int CORE_LAT = 2;
  localparam int TO_CYC   = 16;

  typedef struct { int cyc; int pass; int grp; } ev_t;
  typedef struct { int cyc; int kind; int val; } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   done_q[$];
  chk_t chk_q[$];

  logic drain_req = 1'b0;
  logic inj = 1'b0;
  int   core_limit = 1000;
  int   core_cnt;
  logic [CORE_LAT-1:0] pipe;

  fft64_ctrl_if bus ();

  fft64_ctrl #(.CORE_LAT(CORE_LAT), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: fixed latency, optionally stops accepting after core_limit inputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe     <= '0;
      core_cnt <= 0;
    end else if (bus.core_vld && core_cnt < core_limit) begin
      core_cnt <= core_cnt + 1;
      pipe     <= {pipe[CORE_LAT-2:0], 1'b1};
    end else begin
      pipe     <= {pipe[CORE_LAT-2:0], 1'b0};
    end
  end

  assign bus.core_vld_out = pipe[CORE_LAT-1] | inj;

  function automatic ev_t mk_ev(input int c, input int p, input int g);
    ev_t e;
    e.cyc = c; e.pass = p; e.grp = g;
    return e;
  endfunction

  task automatic push_chk(input int c, input int k, input int v);
    chk_t x;
    x.cyc = c; x.kind = k; x.val = v;
    chk_q.push_back(x);
  endtask

  task automatic push_run(input int c);
    for (int g = 0; g < 8; g++) rd_q.push_back(mk_ev(c + 1 + g, 0, g));
    for (int g = 0; g < 8; g++) rd_q.push_back(mk_ev(c + 12 + g, 1, g));
    for (int g = 0; g < 8; g++) wr_q.push_back(mk_ev(c + 4 + g, 0, g));
    for (int g = 0; g < 8; g++) wr_q.push_back(mk_ev(c + 15 + g, 1, g));
    done_q.push_back(c + 23);
    push_chk(c, 0, 0);
    push_chk(c + 1, 0, 1);
    push_chk(c + 23, 0, 1);
    push_chk(c + 24, 0, 0);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_at(input int c);
    go(c);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    drain_req = 1'b1;
    @(negedge clk);
    #1;
    drain_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_normal();
    int c;
    c = cyc + 1;
    push_run(c);
    start_at(c);
    go(c + 26);
    drain();
  endtask

  // monitor / checker
  initial begin
    ev_t  e;
    int   dc;
    int   got;
    logic prev_rd_en;
    logic [2:0] prev_rd_grp;
    prev_rd_en  = 1'b0;
    prev_rd_grp = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_tests++;
        if ({bus.busy, bus.done, bus.rd_en, bus.rd_grp, bus.rd_pass, bus.core_vld, bus.wn_grp,
             bus.wr_en, bus.wr_grp, bus.wr_pass, bus.err} != 17'd0) begin
          n_fail++;
          $display("FAIL reset_outputs: cyc %0d got busy %b done %b rd_en %b wr_en %b err %b core_vld %b, want all 0",
                   cyc, bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.err, bus.core_vld);
        end
        prev_rd_en  = 1'b0;
        prev_rd_grp = 3'd0;
      end else begin
        n_tests++;
        if ({bus.core_vld, bus.wn_grp} != {prev_rd_en, prev_rd_grp}) begin
          n_fail++;
          $display("FAIL core_align: cyc %0d got core_vld %b wn_grp %0d, want %b %0d",
                   cyc, bus.core_vld, bus.wn_grp, prev_rd_en, prev_rd_grp);
        end
        prev_rd_en  = bus.rd_en;
        prev_rd_grp = bus.rd_grp;
        if (bus.rd_en) begin
          n_tests++;
          if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: cyc %0d pass %0d grp %0d, want no read", cyc, bus.rd_pass, bus.rd_grp);
          end else begin
            e = rd_q.pop_front();
            if (e.cyc != cyc || e.pass != int'(bus.rd_pass) || e.grp != int'(bus.rd_grp)) begin
              n_fail++;
              $display("FAIL rd: got cyc %0d pass %0d grp %0d, want cyc %0d pass %0d grp %0d",
                       cyc, bus.rd_pass, bus.rd_grp, e.cyc, e.pass, e.grp);
            end
          end
        end
        if (bus.wr_en) begin
          n_tests++;
          if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected: cyc %0d pass %0d grp %0d, want no write", cyc, bus.wr_pass, bus.wr_grp);
          end else begin
            e = wr_q.pop_front();
            if (e.cyc != cyc || e.pass != int'(bus.wr_pass) || e.grp != int'(bus.wr_grp)) begin
              n_fail++;
              $display("FAIL wr: got cyc %0d pass %0d grp %0d, want cyc %0d pass %0d grp %0d",
                       cyc, bus.wr_pass, bus.wr_grp, e.cyc, e.pass, e.grp);
            end
          end
        end
        if (bus.done) begin
          n_tests++;
          if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: cyc %0d, want no done", cyc);
          end else begin
            dc = done_q.pop_front();
            if (dc != cyc) begin
              n_fail++;
              $display("FAIL done: got cyc %0d, want cyc %0d", cyc, dc);
            end
          end
        end
      end
      for (int i = chk_q.size() - 1; i >= 0; i--) begin
        if (chk_q[i].cyc == cyc) begin
          n_tests++;
          got = (chk_q[i].kind == 0) ? int'(bus.busy) : int'(bus.err);
          if (got != chk_q[i].val) begin
            n_fail++;
            $display("FAIL %s: cyc %0d got %0d, want %0d",
                     (chk_q[i].kind == 0) ? "busy" : "err", cyc, got, chk_q[i].val);
          end
          chk_q.delete(i);
        end
      end
      if (drain_req) begin
        n_tests++;
        if (rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || chk_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover: cyc %0d got rd %0d wr %0d done %0d chk %0d pending, want 0",
                   cyc, rd_q.size(), wr_q.size(), done_q.size(), chk_q.size());
        end
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        chk_q.delete();
      end
    end
  end

  // stimulus
  initial begin
    int c;
    int s;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // start accepted on the first edge after reset release
    c = cyc;
    push_run(c);
    push_chk(c, 1, 0);
    rst = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    go(c + 26);
    drain();

    // start during a run is ignored
    c = cyc + 1;
    push_run(c);
    start_at(c);
    go(c + 5);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    go(c + 26);
    drain();

    // stray core output in IDLE and in DONE
    c = cyc + 1;
    go(c);
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    push_chk(c + 1, 1, 1);
    push_chk(c + 2, 1, 1);
    s = c + 3;
    push_chk(s, 1, 1);
    push_chk(s + 1, 1, 0);
    push_run(s);
    start_at(s);
    go(s + 23);
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    push_chk(s + 24, 1, 1);
    go(s + 27);
    drain();

    // reset in cycle 14 aborts the run
    c = cyc + 1;
    for (int g = 0; g < 8; g++) rd_q.push_back(mk_ev(c + 1 + g, 0, g));
    for (int g = 0; g < 2; g++) rd_q.push_back(mk_ev(c + 12 + g, 1, g));
    for (int g = 0; g < 8; g++) wr_q.push_back(mk_ev(c + 4 + g, 0, g));
    push_chk(c + 13, 0, 1);
    push_chk(c + 14, 0, 0);
    start_at(c);
    go(c + 14);
    rst = 1'b1;
    go(c + 16);
    rst = 1'b0;
    go(c + 17);
    drain();
    run_normal();

    // back-to-back runs
    c = cyc + 1;
    push_run(c);
    push_run(c + 24);
    start_at(c);
    start_at(c + 24);
    go(c + 50);
    drain();

    // core returns only five pass-0 results
    rst = 1'b1;
    go(cyc + 2);
    rst = 1'b0;
    core_limit = 5;
    c = cyc + 1;
    for (int g = 0; g < 8; g++) rd_q.push_back(mk_ev(c + 1 + g, 0, g));
    for (int g = 0; g < 5; g++) wr_q.push_back(mk_ev(c + 4 + g, 0, g));
`ifdef FFT64_CTRL_TIMEOUT_EN
    push_chk(c + 23, 0, 1);
    push_chk(c + 23, 1, 0);
    push_chk(c + 24, 0, 0);
    push_chk(c + 24, 1, 1);
    start_at(c);
    go(c + 30);
`else
    push_chk(c + 40, 0, 1);
    push_chk(c + 60, 0, 1);
    start_at(c);
    go(c + 61);
`endif
    drain();
    rst = 1'b1;
    go(cyc + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft64_ctrl.md
FFT64_CTRL -- requirements
Module: fft64_ctrl

Interface
REQ-001 Parameter CORE_LAT, default 2: fft_core8 latency in cycles from vld_in to vld_out.
REQ-002 Parameter TO_CYC, default 16: watchdog limit in cycles (used only when FFT64_CTRL_TIMEOUT_EN is defined).
REQ-003 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to run one 64-point transform.
REQ-006 Port busy, output, 1: high in every state except IDLE.
REQ-007 Port done, output, 1: one-cycle pulse at end of transform.
REQ-008 Port rd_en / rd_grp / rd_pass, output, 1/3/1: buffer read strobe, group index 0..7, pass index.
REQ-009 Port core_vld, output, 1: drives fft_core8 vld_in.
REQ-010 Port wn_grp, output, 3: twiddle-set index for the core, aligned with core_vld.
REQ-011 Port core_vld_out, input, 1: fft_core8 vld_out.
REQ-012 Port wr_en / wr_grp / wr_pass, output, 1/3/1: buffer write strobe, group index, pass index.
REQ-013 Port err, output, 1: sticky protocol error flag.

Function
REQ-014 FSM states SHALL be IDLE, RD0, WAIT0, RD1, WAIT1, DONE.
REQ-015 IDLE->RD0 on start; start SHALL be ignored in all other states.
REQ-016 RD0 and RD1 SHALL each last exactly 8 cycles, with rd_en=1 and rd_grp=0..7 ascending; rd_pass=0 in RD0 and 1 in RD1.
REQ-017 RD0->WAIT0 and RD1->WAIT1 after the 8th read; WAIT0->RD1 and WAIT1->DONE on the clock edge that accepts the 8th write of the pass.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 core_vld and wn_grp SHALL equal rd_en and rd_grp delayed by one cycle (1-cycle buffer read latency).
REQ-020 wr_en SHALL equal core_vld_out while in RD*/WAIT* and fewer than 8 writes have been counted in the current pass.
REQ-021 wr_grp SHALL come from a 3-bit write counter cleared on entry to RD0/RD1 and incremented on each wr_en; wr_pass SHALL equal the current pass.
REQ-022 With CORE_LAT=2: start high in cycle 0 gives reads in cycles 1-8, writes in cycles 4-11, reads in cycles 12-19, writes in cycles 15-22, and done in cycle 23.
REQ-023 A core_vld_out that is not accepted as a write (IDLE, DONE, or a 9th pulse in a pass) SHALL set err and SHALL NOT generate wr_en.
REQ-024 err SHALL clear only on reset or when start is accepted.

Reset
REQ-025 While rst=1, the FSM SHALL be IDLE and all counters zero.
REQ-026 While rst=1, busy, done, rd_en, rd_grp, rd_pass, core_vld, wn_grp, wr_en, wr_grp, wr_pass and err SHALL all be 0.
REQ-027 Reset asserted mid-transform SHALL abort immediately with no done pulse.
REQ-028 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 With FFT64_CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT0/WAIT1 and clear on each wr_en.
REQ-030 Under FFT64_CTRL_TIMEOUT_EN, reaching TO_CYC cycles without a write SHALL set err and force IDLE with no done pulse.
REQ-031 Without FFT64_CTRL_TIMEOUT_EN, WAIT states SHALL wait indefinitely and no watchdog logic SHALL exist.

Verification
REQ-032 Reset then start in cycle 0, core model with 2-cycle latency -> rd_grp 0..7 in cycles 1-8 and 12-19, wr_grp 0..7 in cycles 4-11 and 15-22, done=1 only in cycle 23, busy in cycles 1-23.
REQ-033 Start pulsed again in cycle 5 of a run -> ignored; sequence identical to REQ-032, one done pulse.
REQ-034 core_vld_out pulsed in IDLE -> err=1, wr_en=0; next accepted start -> err=0.
REQ-035 rst asserted in cycle 14 -> all outputs 0 in that cycle, no done; a new start runs a full sequence.
REQ-036 FFT64_CTRL_TIMEOUT_EN defined, core returns only 5 pass-0 outputs -> err=1 and IDLE 16 cycles after the 5th write; without the macro, busy stays 1.
REQ-037 Back-to-back start in cycle 24 (first IDLE cycle) -> second transform accepted with done in cycle 47.
